// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential 32x32 multiply/divide (signed and unsigned), one bit per cycle.
// Shift-add multiply and restoring divide share one 2*OPR_L accumulator.
module alu_muldiv_seq #(
    parameter int OPR_L = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [OPR_L-1:0] a,
    input  logic [OPR_L-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [OPR_L-1:0] hi,
    output logic [OPR_L-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(OPR_L) + 1;
    localparam logic [CW-1:0] LAST = CW'(OPR_L - 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [OPR_L-1:0]   r_a, r_b, r_m;
    logic [2*OPR_L-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q, r_neg_r, r_dz_p;
    logic               r_busy, r_done, r_dz;
    logic [OPR_L-1:0]   r_hi, r_lo;

    logic               w_sa, w_sb;
    logic [OPR_L-1:0]   w_abs_a, w_abs_b, w_rem, w_quo;
    logic [OPR_L:0]     w_addend, w_msum, w_shift, w_trial;
    logic [2*OPR_L-1:0] w_mul_next, w_div_next, w_fix;

    assign w_sa     = r_op[0] & r_a[OPR_L-1];
    assign w_sb     = r_op[0] & r_b[OPR_L-1];
    assign w_abs_a  = w_sa ? -r_a : r_a;
    assign w_abs_b  = w_sb ? -r_b : r_b;
    // Multiply: accumulator is {partial product, remaining multiplier bits}
    assign w_addend   = r_acc[0] ? {1'b0, r_m} : '0;
    assign w_msum     = {1'b0, r_acc[2*OPR_L-1:OPR_L]} + w_addend;
    assign w_mul_next = {w_msum, r_acc[OPR_L-1:1]};
    // Divide: accumulator is {remainder, dividend bits shifting into quotient}
    assign w_shift    = {r_acc[2*OPR_L-1:OPR_L], r_acc[OPR_L-1]};
    assign w_trial    = w_shift - {1'b0, r_m};
    assign w_div_next = w_trial[OPR_L] ? {w_shift[OPR_L-1:0], r_acc[OPR_L-2:0], 1'b0}
                                       : {w_trial[OPR_L-1:0], r_acc[OPR_L-2:0], 1'b1};
    assign w_rem = r_acc[2*OPR_L-1:OPR_L];
    assign w_quo = r_acc[OPR_L-1:0];
    assign w_fix = r_op[1] ? {r_neg_r ? -w_rem : w_rem, r_neg_q ? -w_quo : w_quo}
                           : (r_neg_q ? -r_acc : r_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz_p  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= op;
                    r_a     <= a;
                    r_b     <= b;
                    r_busy  <= 1'b1;
                    r_state <= S_PREP;
                end
                S_PREP: begin
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_cnt   <= '0;
                    if (r_op[1] && r_b == '0) begin
                        r_acc   <= {r_a, {OPR_L{1'b1}}};
                        r_dz_p  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_m     <= r_op[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{OPR_L{1'b0}}, r_op[1] ? w_abs_a : w_abs_b};
                        r_dz_p  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_acc   <= w_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hi    <= r_acc[2*OPR_L-1:OPR_L];
                    r_lo    <= r_acc[OPR_L-1:0];
                    r_dz    <= r_dz_p;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed and random checks of alu_muldiv_seq against an arithmetic reference.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, div_zero;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          checks = 0;
    int          errors = 0;

    alu_muldiv_seq #(.OPR_L(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        ed = 1'b0;
        eh = '0;
        el = '0;
        if (o == 2'd0) begin
            p = {32'd0, x} * {32'd0, y};
            {eh, el} = p;
        end else if (o == 2'd1) begin
            p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            {eh, el} = p;
        end else if (y == 32'd0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else if (o == 2'd2) begin
            el = x / y;
            eh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            el = 32'h8000_0000;
            eh = 32'd0;
        end else begin
            el = sx / sy;
            eh = sx % sy;
        end
    endtask

    // Caller is at a negedge; start is driven immediately.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int pulse_at, input bit b2b);
        logic [31:0] eh, el, ph, pl;
        logic        ed, pdz;
        int          n, busy_n, lat;
        bit          stable;
        model(o, x, y, eh, el, ed);
        lat = (o[1] && y == 32'd0) ? 2 : 35;
        ph = hi; pl = lo; pdz = div_zero;
        stable = 1'b1;
        busy_n = 0;
        n = 0;
        start = 1'b1; op = o; a = x; b = y;
        do begin
            @(negedge clk);
            n++;
            start = (n == pulse_at);
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (!done) begin
                busy_n += int'(busy);
                if (hi !== ph || lo !== pl || div_zero !== pdz) stable = 1'b0;
            end
        end while (!done && n < 60);
        start = 1'b0;
        check("latency", 64'(n - 1), 64'(lat));
        check("busy_cycles", 64'(busy_n), 64'(lat));
        check("hold_while_busy", 64'(stable), 64'd1);
        check("result_hi", 64'(hi), 64'(eh));
        check("result_lo", 64'(lo), 64'(el));
        check("div_zero", 64'(div_zero), 64'(ed));
        check("busy_at_done", 64'(busy), 64'd0);
        if (!b2b) begin
            @(negedge clk);
            check("done_one_cycle", {62'd0, done, busy}, 64'd0);
            check("hold_after", {hi, lo}, {eh, el});
        end
    endtask

    logic [31:0] ra, rb;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd2, 32'd100, 32'd0, 0, 0);
        run_op(2'd2, 32'd100, 32'd7, 0, 0);
        run_op(2'd0, 32'd1234, 32'd5678, 12, 0);
        run_op(2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 35, 0);
        run_op(2'd3, 32'd0, 32'd0, 0, 1);
        run_op(2'd3, 32'h8000_0001, 32'd3, 0, 1);
        run_op(2'd0, 32'hDEAD_BEEF, 32'h0000_0010, 0, 0);
        // Abort mid-RUN with asynchronous reset
        start = 1'b1; op = 2'd0; a = 32'hFFFF_0000; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                seen += int'(done) + int'(busy);
            end
            check("no_done_after_abort", 64'(seen), 64'd0);
        end
        run_op(2'd0, 32'd6, 32'd7, 0, 0);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 100);
                default: rb = $urandom;
            endcase
            run_op(2'($urandom), ra, rb, (i % 3 == 0) ? int'($urandom_range(2, 34)) : 0,
                   bit'($urandom_range(0, 1)));
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
